// File: rtl/vx_gpu_pkg.sv
// Shared execute-payload layout and sizing helpers for the execute-stage arbiter.
package VX_gpu_pkg;

  localparam int EXEC_SOP_BIT = 1;
  localparam int EXEC_EOP_BIT = 0;

  // Index width for a requester vector, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_exec_rr_picker.sv
// Combinational rotate-priority picker: first valid requester after rr_ptr, with wrap.
module vx_exec_rr_picker
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  localparam int SEL_W = sel_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [SEL_W-1:0]      rr_ptr,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [SEL_W-1:0]      idx,
  output logic                  any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_INPUTS; i++) begin
      j = (int'(rr_ptr) + i) % NUM_INPUTS;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/vx_execute_arbiter.sv
// Packet-aware round-robin arbiter sharing one execute port among NUM_INPUTS requesters.
// Optional perf counters are built when VX_EXEC_ARB_PERF_EN is defined.
module vx_execute_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 256,
  localparam int SEL_W = sel_width(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            req_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_INPUTS-1:0]            req_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  input  logic                             out_ready,
  output logic [SEL_W-1:0]                 out_sel
`ifdef VX_EXEC_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_stalls,
  output logic [31:0]                      perf_lock_bubbles
`endif
);

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [SEL_W-1:0]      sel_p1;
  logic                  lock;
  logic [SEL_W-1:0]      lock_idx;
  logic [SEL_W-1:0]      rr_ptr;

  logic                  en;
  logic [NUM_INPUTS-1:0] pick_grant;
  logic [SEL_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  beat_eop;

  assign en = !vld_p1 || out_ready;

  vx_exec_rr_picker #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_picker (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // While a packet is open only its owner may be granted; otherwise a bubble.
  always_comb begin
    grant   = pick_grant;
    gnt_idx = pick_idx;
    gnt_any = pick_any;
    if (lock) begin
      grant   = '0;
      gnt_idx = lock_idx;
      gnt_any = req_valid[lock_idx];
      grant[lock_idx] = req_valid[lock_idx];
    end
  end

  assign req_ready = grant & {NUM_INPUTS{en}};
  assign xfer      = gnt_any && en;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign beat_eop = sel_data[EXEC_EOP_BIT];

  // ---- output register stage (p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      sel_p1   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= SEL_W'(NUM_INPUTS - 1);
    end else if (en) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= sel_data;
        sel_p1  <= gnt_idx;
        // A beat without eop opens (or continues) a packet, sop or not.
        if (beat_eop) begin
          lock   <= 1'b0;
          rr_ptr <= gnt_idx;
        end else if (!lock) begin
          lock     <= 1'b1;
          lock_idx <= gnt_idx;
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

`ifdef VX_EXEC_ARB_PERF_EN
  logic [31:0] stalls_q;
  logic [31:0] bubbles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q  <= '0;
      bubbles_q <= '0;
    end else begin
      if (vld_p1 && !out_ready) stalls_q <= stalls_q + 32'd1;
      if (lock && !req_valid[lock_idx]) bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_stalls       = stalls_q;
  assign perf_lock_bubbles = bubbles_q;
`endif

endmodule
